gate_sweep_ctrl: RTL and testbench

Sequencer that exhaustively exercises one external combinational gate of NUM_IN inputs. It drives every input combination in ascending binary order and waits a programmable settle time after each. It then samples the gate output and compares it against an expected truth table. It reports a per-vector capture, a per-vector fail mask and an overall PASS, giving a hardware self-check harness for the basic gate library.

---
 rtl/gate_sweep_pkg.sv | 18 +
 rtl/gate_sweep_settle_cnt.sv | 31 +++
 rtl/gate_sweep_ctrl.sv | 136 +++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate sweep controller.
// The optional stop-on-fail behaviour is controlled by GATE_SWEEP_STOP_ON_FAIL_EN (see top).
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StSample = 2'd2,
        StFinish = 2'd3
    } state_e;

    localparam int unsigned CNT_W = 8;

    function automatic int unsigned nv_of(input int unsigned num_in);
        return 32'd1 << num_in;
    endfunction

endpackage

// File: rtl/gate_sweep_settle_cnt.sv
// Settle-time counter: clears to zero, counts while enabled, and flags the
// final settle cycle (count == SETTLE_CYCLES-1).
module gate_sweep_settle_cnt
    import gate_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] TcVal = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc = (cnt_q == TcVal);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive sweep of an external NUM_IN-input gate against an expected truth table.
// Define GATE_SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int unsigned NUM_IN        = 2,
    parameter int unsigned SETTLE_CYCLES = 2,
    localparam int unsigned NV           = nv_of(NUM_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NV-1:0]     tt_exp,
    output logic [NUM_IN-1:0] gate_in,
    input  logic              gate_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [NV-1:0]     captured,
    output logic [NV-1:0]     fail_mask
);

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    localparam bit StopOnFail = 1'b1;
`else
    localparam bit StopOnFail = 1'b0;
`endif

    // One extra index bit so the last-vector compare never wraps.
    localparam logic [NUM_IN:0] LastIdx = (NUM_IN + 1)'(NV - 1);

    state_e            state_q, state_d;
    logic [NUM_IN:0]   idx_q, idx_d;
    logic [NV-1:0]     tt_q, tt_d;
    logic [NV-1:0]     cap_q, cap_d;
    logic [NV-1:0]     fm_q, fm_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              cnt_clr, cnt_en, cnt_tc;
    logic              mismatch;

    gate_sweep_settle_cnt #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .tc   (cnt_tc)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tt_d     = tt_q;
        cap_d    = cap_q;
        fm_d     = fm_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        mismatch = gate_out ^ tt_q[idx_q[NUM_IN-1:0]];

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    tt_d    = tt_exp;
                    cap_d   = '0;
                    fm_d    = '0;
                    pass_d  = 1'b0;
                    idx_d   = '0;
                    cnt_clr = 1'b1;
                    busy_d  = 1'b1;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                cap_d[idx_q[NUM_IN-1:0]] = gate_out;
                fm_d[idx_q[NUM_IN-1:0]]  = mismatch;
                if ((idx_q == LastIdx) || (StopOnFail && mismatch)) begin
                    // PASS must reflect the vector sampled on this same edge.
                    done_d  = 1'b1;
                    pass_d  = ~|fm_d;
                    state_d = StFinish;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    cnt_clr = 1'b1;
                    state_d = StSettle;
                end
            end
            StFinish: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            tt_q    <= '0;
            cap_q   <= '0;
            fm_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tt_q    <= tt_d;
            cap_q   <= cap_d;
            fm_q    <= fm_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign gate_in   = idx_q[NUM_IN-1:0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign captured  = cap_q;
    assign fail_mask = fm_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Self-checking bench for gate_sweep_ctrl: two instances (settle 2 and settle 1)
// driven by a behavioural gate and compared against a truth-table level model.
module tb_gate_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0;
    logic       start1 = 1'b0;
    logic [3:0] tt_exp = '0;
    logic [3:0] gt0 = '0;
    logic [3:0] gt1 = '0;

    logic [1:0] gin0, gin1;
    logic       gout0, gout1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [3:0] cap0, cap1, fm0, fm1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural gates under test: output is the gate's truth table indexed by its inputs.
    assign gout0 = gt0[gin0];
    assign gout1 = gt1[gin1];

    gate_sweep_ctrl #(
        .NUM_IN       (2),
        .SETTLE_CYCLES(2)
    ) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start0),
        .tt_exp   (tt_exp),
        .gate_in  (gin0),
        .gate_out (gout0),
        .busy     (busy0),
        .done     (done0),
        .pass     (pass0),
        .captured (cap0),
        .fail_mask(fm0)
    );

    gate_sweep_ctrl #(
        .NUM_IN       (2),
        .SETTLE_CYCLES(1)
    ) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start1),
        .tt_exp   (tt_exp),
        .gate_in  (gin1),
        .gate_out (gout1),
        .busy     (busy1),
        .done     (done1),
        .pass     (pass1),
        .captured (cap1),
        .fail_mask(fm1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic observe(input bit s, output logic [1:0] g, output logic b, output logic d,
                           output logic p, output logic [3:0] c, output logic [3:0] f);
        if (s) begin
            g = gin1; b = busy1; d = done1; p = pass1; c = cap1; f = fm1;
        end else begin
            g = gin0; b = busy0; d = done0; p = pass0; c = cap0; f = fm0;
        end
    endtask

    // mode 0: quiet; 1: START pulses at cycles 3 and 7 with TT_EXP cleared; 2: random noise.
    task automatic run_sweep(input bit s, input logic [3:0] tt, input logic [3:0] gt,
                             input int mode);
        int settle, per, last, exp_done, n, want_g;
        logic [4:0] mask;
        logic [3:0] exp_cap, exp_fm;
        logic [1:0] g;
        logic b, d, p;
        logic [3:0] c, f;
        bit got;

        settle = s ? 1 : 2;
        per    = settle + 1;
        last   = 3;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        for (int k = 0; k < 4; k++) begin
            if (gt[k] != tt[k]) begin
                last = k;
                break;
            end
        end
`endif
        mask     = (5'd1 << (last + 1)) - 5'd1;
        exp_cap  = gt & mask[3:0];
        exp_fm   = (gt ^ tt) & mask[3:0];
        exp_done = (last + 1) * per;

        @(negedge clk);
        if (s) gt1 = gt; else gt0 = gt;
        tt_exp = tt;
        start0 = !s;
        start1 = s;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        observe(s, g, b, d, p, c, f);
        check("accept_busy", b, 1'b1);
        check("accept_gate_in", g, 2'd0);
        check("accept_cleared", {d, p, c, f}, '0);

        n   = 0;
        got = 1'b0;
        while (n < 200 && !got) begin
            @(negedge clk);
            n++;
            observe(s, g, b, d, p, c, f);
            want_g = (n / per > last) ? last : n / per;
            check("gate_in_seq", g, want_g);
            if (d) got = 1'b1;
            else if (mode == 1) begin
                start0 = !s && (n == 3 || n == 7);
                start1 = s && (n == 3 || n == 7);
                if (n == 3) tt_exp = 4'b0000;
            end else if (mode == 2) begin
                start0 = !s && ($urandom_range(0, 1) == 1);
                start1 = s && ($urandom_range(0, 1) == 1);
                tt_exp = 4'($urandom);
            end
        end
        start0 = 1'b0;
        start1 = 1'b0;
        check("done_edge", got ? n : 32'hffff_ffff, exp_done);
        if (got) begin
            check("captured", c, exp_cap);
            check("fail_mask", f, exp_fm);
            check("pass", p, (exp_fm == 4'd0));
            check("busy_in_finish", b, 1'b1);
            @(negedge clk);
            observe(s, g, b, d, p, c, f);
            check("done_pulse_end", d, 1'b0);
            check("busy_end", b, 1'b0);
            check("pass_hold", p, (exp_fm == 4'd0));
            check("gate_in_hold", g, last);
        end
    endtask

    initial begin
        #1;
        check("rst_outputs0", {gin0, busy0, done0, pass0, cap0, fm0}, '0);
        check("rst_outputs1", {gin1, busy1, done1, pass1, cap1, fm1}, '0);
        #11 rst_n = 1'b1;

        run_sweep(1'b0, 4'b1110, 4'b1110, 0);   // correct OR gate
        run_sweep(1'b0, 4'b1000, 4'b1110, 0);   // AND table against OR gate
        run_sweep(1'b1, 4'b1110, 4'b0000, 0);   // stuck-at-0, settle 1
        run_sweep(1'b0, 4'b1110, 4'b1110, 1);   // START while busy
        run_sweep(1'b0, 4'b1110, 4'b0000, 0);   // stuck-at-0, settle 2

        // Asynchronous reset mid-sweep after vector 0 has been captured.
        @(negedge clk);
        gt0 = 4'b1111;
        tt_exp = 4'b1111;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", busy0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", {gin0, busy0, done0, pass0, cap0, fm0}, '0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_rst", {busy0, done0, cap0}, '0);
        run_sweep(1'b0, 4'b0110, 4'b0110, 0);   // XOR gate after reset

        for (int i = 0; i < 16; i++) begin
            run_sweep(1'($urandom), 4'($urandom), 4'($urandom), 2 * int'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
